// File: rtl/kes_ibm.sv
// Key-equation solver: inversionless Berlekamp-Massey over GF(16).
// Takes S0..S3 and produces the error-locator polynomial for the Chien stage.
module kes_ibm (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0][3:0] syndrome,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0][3:0] lambda,
  output logic [1:0]      deg,
  output logic            uncorrectable
);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  // GF(2^4) multiply, reduced by x^4+x+1
  function automatic logic [3:0] gf_mul(
    input logic [3:0] x,
    input logic [3:0] y
  );
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (y[i]) p ^= 7'(x) << i;
    for (int k = 6; k >= 4; k--)
      if (p[k]) p ^= 7'h13 << (k - 4);
    return p[3:0];
  endfunction

  state_t          state;
  logic [1:0]      r;
  logic [3:0][3:0] syn;
  logic [3:0][3:0] lam;
  logic [3:0][3:0] b;
  logic [3:0]      gam;
  logic [2:0]      l;

  logic [3:0]      delta;
  logic [3:0][3:0] b_sh;
  logic [3:0][3:0] lam_n;
  logic [3:0][3:0] b_n;
  logic [3:0]      gam_n;
  logic [2:0]      l_n;
  logic            upd;
  logic [2:0]      adeg;
  logic            unc_n;
  logic [1:0]      deg_n;

  always_comb begin
    delta = gf_mul(lam[0], syn[r]);
    if (r >= 2'd1)
      delta ^= gf_mul(lam[1], syn[r - 2'd1]);
    if (r >= 2'd2)
      delta ^= gf_mul(lam[2], syn[r - 2'd2]);

    // x*B, dropping the x^4 term
    b_sh = {b[2:0], 4'h0};
    for (int i = 0; i < 4; i++)
      lam_n[i] = gf_mul(gam, lam[i])
               ^ gf_mul(delta, b_sh[i]);

    upd   = (delta != 4'h0) &&
            ({l, 1'b0} <= {2'b00, r});
    b_n   = upd ? lam : b_sh;
    gam_n = upd ? delta : gam;
    l_n   = upd ? ({1'b0, r} + 3'd1 - l) : l;

    adeg = 3'd0;
    for (int i = 1; i < 4; i++)
      if (lam_n[i] != 4'h0) adeg = 3'(i);

    unc_n = (l_n > 3'd2) ||
            (lam_n[3] != 4'h0) ||
            (adeg != l_n);
    deg_n = (l_n > 3'd3) ? 2'd3 : l_n[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      r             <= 2'd0;
      syn           <= '0;
      lam           <= 16'h0001;
      b             <= 16'h0001;
      gam           <= 4'h1;
      l             <= 3'd0;
      lambda        <= 12'h001;
      deg           <= 2'd0;
      uncorrectable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            syn      <= syndrome;
            r        <= 2'd0;
            lam      <= 16'h0001;
            b        <= 16'h0001;
            gam      <= 4'h1;
            l        <= 3'd0;
            in_ready <= 1'b0;
            state    <= ITER;
          end
        end
        ITER: begin
          lam <= lam_n;
          b   <= b_n;
          gam <= gam_n;
          l   <= l_n;
          r   <= r + 2'd1;
          if (r == 2'd3) begin
            lambda        <= lam_n[2:0];
            deg           <= deg_n;
            uncorrectable <= unc_n;
            out_valid     <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/kes_ibm.md
KES_IBM -- requirements
Module: kes_ibm

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; asynchronous, active-high.
REQ-003 in_valid  input  1  syndrome set valid.
REQ-004 in_ready  output  1  block can accept a syndrome set.
REQ-005 syndrome[3:0]  input  4 each  GF(16) syndromes S0..S3.
REQ-006 out_valid  output  1  lambda result valid.
REQ-007 out_ready  input  1  downstream Chien stage accepts result.
REQ-008 lambda[2:0]  output  4 each  error-locator coefficients Λ0..Λ2; lambda[0] is the constant term; consumed directly by the Chien search stage.
REQ-009 deg  output  2  final LFSR length L, saturating at 3.
REQ-010 uncorrectable  output  1  more than 2 symbol errors detected.

Function
REQ-011 Arithmetic: GF(2^4), primitive polynomial x^4+x+1, α=4'd2; addition is XOR; multiplication is combinational, with no lookup RAM.
REQ-012 Algorithm: inversionless Berlekamp-Massey over 4 iterations r=0..3.
- Init: Λ=1, B=1, L=0, γ=1.
- Each iteration: δ=Σ_{j=0..2} Λj·S(r−j), with terms for r−j<0 omitted.
- Λ' = γ·Λ + δ·x·B.
- If δ≠0 and 2L≤r: B=Λ (old), L=r+1−L, γ=δ.
- Otherwise: B=x·B, and L and γ are unchanged.
REQ-013 Internal Λ and B are 4 coefficients wide (degree ≤3); terms shifted beyond x^3 are discarded.
REQ-014 FSM states:
- IDLE: in_ready=1; on in_valid latch S0..S3 and go to ITER with r=0.
- ITER: one iteration per cycle; after r=3 go to DONE.
- DONE: out_valid=1; on out_ready go to IDLE.
REQ-015 Latency: handshake accepted in cycle N → out_valid=1 in cycle N+5; maximum throughput is one set per 6 cycles.
REQ-016 in_ready=0 in ITER and DONE; in_valid in those states is ignored and not queued.
REQ-017 lambda, deg and uncorrectable are registered and held stable while out_valid=1 && out_ready=0, for any number of stall cycles.
REQ-018 Output Λ is a nonzero scalar multiple of the true locator; roots are identical; no normalisation is performed.
REQ-019 uncorrectable=1 iff any of the following hold:
- L>2;
- final Λ3≠0;
- actual degree of Λ ≠ L.
REQ-020 All-zero syndromes SHALL produce lambda={0,0,1}, deg=0, uncorrectable=0 with the standard 5-cycle latency; there is no fast path.
REQ-021 The syndrome register is captured only on in_valid && in_ready; changes on syndrome inputs at any other time have no effect.

Reset
REQ-022 rst=1 at any time (including mid-ITER or DONE) SHALL immediately force:
- FSM to IDLE;
- in_ready=1 after release, out_valid=0;
- lambda={0,0,1}, deg=0, uncorrectable=0;
- internal Λ, B, γ, L, r and syndrome registers to init values.
A result in progress is discarded.
REQ-023 The first handshake is accepted on the first rising edge with rst=0 and in_valid=1.

Verification
REQ-024 S={0,0,0,0} → lambda={Λ0=1,Λ1=0,Λ2=0}, deg=0, uncorrectable=0, out_valid 5 cycles after accept.
REQ-025 Single error: S={S0=1,S1=9,S2=13,S3=15} → lambda={1,9,0}, deg=1, uncorrectable=0; downstream Chien locator=8'b0000_0001.
REQ-026 Double error: S={0,4,3,5} → lambda={3,12,2}, deg=2, uncorrectable=0; Chien locator=8'b0000_0011.
REQ-027 Degree mismatch: S={1,0,0,0} → lambda={1,0,0}, deg=1, uncorrectable=1.
REQ-028 Backpressure: REQ-026 vector with out_ready=0 for 10 cycles → outputs stable and in_ready=0 throughout; out_ready=1 → IDLE next cycle; the next set is accepted on the following in_valid.
REQ-029 Reset mid-operation: assert rst during ITER cycle 2 of REQ-025 → out_valid=0 and lambda={1,0,0} immediately; after release, REQ-024 vector yields the REQ-024 result exactly.
